serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing a - b - bin, one bit per clock, LSB first.
- Sequential stage built around the single-bit full subtractor cell: feeds it one operand bit pair per cycle, keeps the borrow in a flip-flop and collects the difference bits in a shift register.
- Trades WIDTH cycles of latency for one full-subtractor cell. Used where area matters more than throughput.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2 to 32).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a subtraction; sampled only in IDLE or DONE.
- a  input  WIDTH  minuend; sampled on the edge that accepts start.
- b  input  WIDTH  subtrahend; sampled on the edge that accepts start.
- bin  input  1  initial borrow-in; sampled on the edge that accepts start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; high while in DONE.
- diff  output  WIDTH  registered result of a - b - bin, modulo 2^WIDTH.
- bout  output  1  final borrow-out. High when a < b + bin (unsigned).

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; busy=0, done=0, diff=0, bout=0. All internal shift registers, borrow flop and bit counter are cleared.
- Reset mid-operation: the operation in flight is abandoned. No done pulse is generated and the outputs take their reset values.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 on an edge (E0) does the following:
  - loads a into the A shift register and b into the B shift register;
  - loads bin into the borrow flop;
  - clears the bit counter and result shift register;
  - moves to SHIFT.
  With start=0 the block stays in IDLE.
- SHIFT, on each edge:
  - Take the current LSBs: ai=A[0], bi=B[0], br=borrow flop.
  - Compute di = ai ^ bi ^ br.
  - Compute bo = (~ai & bi) | (~(ai ^ bi) & br).
  - Shift A and B right by 1.
  - Shift di into the result register from the MSB side.
  - borrow <= bo; counter <= counter + 1.
- SHIFT exit: on the edge that processes bit WIDTH-1 (edge E_WIDTH):
  - diff <= final result register value, including that last bit;
  - bout <= bo;
  - move to DONE.
- Latency: done is high in the cycle after E_WIDTH, i.e. exactly WIDTH edges after the edge that accepted start.
- DONE: done=1 for exactly one cycle.
  - If start=1 on that edge, the new operands are accepted exactly as in IDLE (back-to-back operation, no bubble). The block moves to SHIFT and done drops.
  - Otherwise the block moves to IDLE.
- start while in SHIFT is ignored; operands and result are unaffected.
- diff and bout change only on the edge that enters DONE (or on reset). They hold their values through IDLE and through the following operation until it completes.
- busy=1 exactly in SHIFT. busy and done are never high at the same time.
- Counter width is clog2(WIDTH)+1. There is no wrap-around within one operation.
- Operand changes while in SHIFT must not affect the result; only the values sampled at start are used.

Test Plan (WIDTH=8):
- a=100, b=37, bin=0, single start pulse -> done pulse exactly 8 edges later; diff=63 (0x3F), bout=0. busy=1 for 8 cycles.
- a=37, b=100, bin=0 -> diff=0xC1, bout=1. Second case: a=0, b=0, bin=1 -> diff=0xFF, bout=1.
- a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0. Second case: a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
- Start 0x55-0x22. Pulse start with a=0, b=0xFF at cycle 3 of SHIFT and change a and b every cycle -> result is still diff=0x33, bout=0, with a single done pulse.
- Back-to-back: hold start=1 with 10-3 then 3-10 presented in the DONE cycle -> first done gives diff=7, bout=0. Second done follows 8 edges later with diff=0xF9, bout=1, and there is no IDLE cycle in between.
- Assert rst at cycle 4 of SHIFT (asynchronously, mid-cycle) -> busy, done, diff and bout go to 0 immediately, with no done pulse. A fresh 200-199 then yields diff=1, bout=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// using a single full-subtractor cell, a borrow flop and a result shift register.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             borrow;
   logic [CW-1:0]    count;

   logic             ai;
   logic             bi;
   logic             di;
   logic             bo;
   logic [WIDTH-1:0] res_next;

   // Full-subtractor cell working on the current LSBs and the stored borrow.
   always_comb begin
      ai       = a_sr[0];
      bi       = b_sr[0];
      di       = ai ^ bi ^ borrow;
      bo       = (~ai & bi) | (~(ai ^ bi) & borrow);
      res_next = {di, res_sr[WIDTH-1:1]};
   end

   // IDLE and DONE share the accept path, which gives back-to-back starts with no bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         borrow <= 1'b0;
         count  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         diff   <= '0;
         bout   <= 1'b0;
      end else if (state == SHIFT) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         res_sr <= res_next;
         borrow <= bo;
         count  <= count + CW'(1);
         if (count == LAST) begin
            diff  <= res_next;
            bout  <= bo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
         end
      end else begin
         done <= 1'b0;
         if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            res_sr <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
         end else begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results,
// an independent monitor pops and compares them whenever done pulses.
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   int checks = 0;
   int errors = 0;
   logic [WIDTH:0] exp_q[$];

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a    (a),
      .b    (b),
      .bin  (bin),
      .busy (busy),
      .done (done),
      .diff (diff),
      .bout (bout)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bv_in);
      a     = av;
      b     = bv;
      bin   = bv_in;
      start = 1'b1;
   endtask

   task automatic push_expected(input logic [WIDTH-1:0] d, input logic bo);
      exp_q.push_back({bo, d});
   endtask

   // Steps negedges until done; drops start after the accepting edge unless hold is set.
   task automatic run_to_done(input bit hold, output int cyc, output int busy_cnt);
      cyc      = 0;
      busy_cnt = 0;
      while (cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1 && !hold) start = 1'b0;
         if (done) break;
         if (busy) busy_cnt++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected done", cyc);
      end
   endtask

   // Monitor: every done cycle is matched against the oldest expected result.
   initial begin
      logic [WIDTH:0] e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            check_output("busy_done_exclusive", 32'(busy), 32'd0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_done: got done=1, expected no pending result");
            end else begin
               e = exp_q.pop_front();
               check_output("diff", 32'(diff), 32'(e[WIDTH-1:0]));
               check_output("bout", 32'(bout), 32'(e[WIDTH]));
            end
         end
      end
   end

   initial begin
      int cyc;
      int busy_cnt;
      int done_cnt;
      logic [WIDTH-1:0] va[4] = '{8'd37, 8'h00, 8'h80, 8'hFF};
      logic [WIDTH-1:0] vb[4] = '{8'd100, 8'h00, 8'h01, 8'hFF};
      logic             vi[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [WIDTH-1:0] vd[4] = '{8'hC1, 8'hFF, 8'h7F, 8'hFF};
      logic             vo[4] = '{1'b1, 1'b1, 1'b0, 1'b1};

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      #3;
      check_output("reset_busy", 32'(busy), 32'd0);
      check_output("reset_done", 32'(done), 32'd0);
      check_output("reset_diff", 32'(diff), 32'd0);
      check_output("reset_bout", 32'(bout), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Basic subtraction with latency and busy-length checks
      apply_stimulus(8'd100, 8'd37, 1'b0);
      push_expected(8'h3F, 1'b0);
      run_to_done(1'b0, cyc, busy_cnt);
      check_output("latency", 32'(cyc), 32'(WIDTH + 1));
      check_output("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
      @(negedge clk);
      check_output("done_one_cycle", 32'(done), 32'd0);
      check_output("idle_not_busy", 32'(busy), 32'd0);
      check_output("diff_holds_idle", 32'(diff), 32'h3F);

      // Borrow and wrap-around corner cases
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(va[i], vb[i], vi[i]);
         push_expected(vd[i], vo[i]);
         run_to_done(1'b0, cyc, busy_cnt);
         @(negedge clk);
      end

      // Operands change and start pulses during SHIFT; only the sampled values count
      apply_stimulus(8'h55, 8'h22, 1'b0);
      push_expected(8'h33, 1'b0);
      cyc      = 0;
      done_cnt = 0;
      while (cyc < 50 && done_cnt == 0) begin
         @(negedge clk);
         cyc++;
         if (done) done_cnt++;
         check_output("diff_holds_shift", 32'(diff), done ? 32'h33 : 32'hFF);
         a     = 8'($urandom);
         b     = 8'($urandom);
         start = 1'b0;
         if (cyc == 3) begin
            a     = 8'h00;
            b     = 8'hFF;
            start = 1'b1;
         end
      end
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check_output("single_done", 32'(done_cnt), 32'd1);

      // Back-to-back: new operands presented in the DONE cycle with start held
      apply_stimulus(8'd10, 8'd3, 1'b0);
      push_expected(8'd7, 1'b0);
      run_to_done(1'b1, cyc, busy_cnt);
      a = 8'd3;
      b = 8'd10;
      push_expected(8'hF9, 1'b1);
      @(negedge clk);
      check_output("no_bubble_busy", 32'(busy), 32'd1);
      check_output("diff_holds_b2b", 32'(diff), 32'd7);
      run_to_done(1'b0, cyc, busy_cnt);
      check_output("b2b_latency", 32'(cyc), 32'(WIDTH));
      @(negedge clk);

      // Asynchronous reset in the middle of SHIFT abandons the operation
      apply_stimulus(8'd100, 8'd37, 1'b0);
      repeat (4) begin
         @(negedge clk);
         start = 1'b0;
      end
      #2 rst = 1'b1;
      #1;
      check_output("midreset_busy", 32'(busy), 32'd0);
      check_output("midreset_done", 32'(done), 32'd0);
      check_output("midreset_diff", 32'(diff), 32'd0);
      check_output("midreset_bout", 32'(bout), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      apply_stimulus(8'd200, 8'd199, 1'b0);
      push_expected(8'd1, 1'b0);
      run_to_done(1'b0, cyc, busy_cnt);
      repeat (3) @(negedge clk);

      check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
